// File: rtl/despachador_hash_pkg.sv
// Shared types and widths for the micro_ucr_hash job dispatcher.
// Holds the FSM encoding, the result status codes and the counter widths.
package despachador_pkg;

    localparam int DATOS_W    = 96;
    localparam int TARGET_W   = 8;
    localparam int BOUNTY_W   = 124;
    localparam int CICLOS_W   = 16;
    localparam int TIMEOUTS_W = 8;

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        ARRANQUE = 2'b01,
        ESPERA   = 2'b10,
        ENTREGA  = 2'b11
    } estado_fsm_t;

    typedef logic [1:0] estado_res_t;

    localparam estado_res_t EST_OK      = 2'b00;
    localparam estado_res_t EST_TIMEOUT = 2'b01;

endpackage

// File: rtl/despachador_hash_if.sv
// Host-side bus of the dispatcher: job intake and result return handshakes.
// The master modport is the host; the slave modport is the dispatcher.
interface despachador_hash_if;
    import despachador_pkg::*;

    logic                trabajo_valido;
    logic                trabajo_listo;
    logic [DATOS_W-1:0]  trabajo_datos;
    logic [TARGET_W-1:0] trabajo_target;

    logic                resultado_valido;
    logic                resultado_listo;
    logic [BOUNTY_W-1:0] resultado_bounty;
    estado_res_t         resultado_estado;
    logic [CICLOS_W-1:0] resultado_ciclos;

    modport master (
        output trabajo_valido, trabajo_datos, trabajo_target, resultado_listo,
        input  trabajo_listo, resultado_valido, resultado_bounty,
               resultado_estado, resultado_ciclos
    );

    modport slave (
        input  trabajo_valido, trabajo_datos, trabajo_target, resultado_listo,
        output trabajo_listo, resultado_valido, resultado_bounty,
               resultado_estado, resultado_ciclos
    );

endinterface

// File: rtl/despachador_hash_contador.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module contador_saturante #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [ANCHO-1:0] q
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + ANCHO'(1);
        end
    end

endmodule

// File: rtl/despachador_hash.sv
// Job dispatcher for micro_ucr_hash: latches a job, strobes inicio, waits for
// terminado under a timeout guard and hands the result downstream.
module despachador_hash
    import despachador_pkg::*;
#(
    parameter int INICIO_CICLOS  = 2,
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    despachador_hash_if.slave     bus,
    output logic [DATOS_W-1:0]    bloque_datos,
    output logic [TARGET_W-1:0]   target,
    output logic                  inicio,
    input  logic [BOUNTY_W-1:0]   bounty,
    input  logic                  terminado,
    output logic [TIMEOUTS_W-1:0] contador_timeouts,
    output logic                  ocupado
);

    localparam int FASE_W = (INICIO_CICLOS > 1) ? $clog2(INICIO_CICLOS) : 1;

    estado_fsm_t         estado;
    logic [FASE_W-1:0]   fase;
    logic [CICLOS_W-1:0] ciclos_q;
    logic                fin_arranque;
    logic                expira;

    assign fin_arranque = (estado == ARRANQUE) && (fase == FASE_W'(INICIO_CICLOS - 1));
    // Timeout fires on the cycle whose count would reach the limit; terminado wins a tie.
    assign expira = (estado == ESPERA) && !terminado &&
                    (ciclos_q == CICLOS_W'(TIMEOUT_CICLOS - 1));

    contador_saturante #(.ANCHO(CICLOS_W)) u_ciclos (
        .clk   (clk),
        .reset (reset),
        .clr   (fin_arranque),
        .en    (estado == ESPERA),
        .q     (ciclos_q)
    );

    contador_saturante #(.ANCHO(TIMEOUTS_W)) u_timeouts (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (expira),
        .q     (contador_timeouts)
    );

    assign bus.resultado_ciclos = ciclos_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado               <= REPOSO;
            fase                 <= '0;
            bloque_datos         <= '0;
            target               <= '0;
            inicio               <= 1'b0;
            ocupado              <= 1'b0;
            bus.trabajo_listo    <= 1'b0;
            bus.resultado_valido <= 1'b0;
            bus.resultado_bounty <= '0;
            bus.resultado_estado <= EST_OK;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.trabajo_valido && bus.trabajo_listo) begin
                        bloque_datos      <= bus.trabajo_datos;
                        target            <= bus.trabajo_target;
                        fase              <= '0;
                        inicio            <= 1'b1;
                        ocupado           <= 1'b1;
                        bus.trabajo_listo <= 1'b0;
                        estado            <= ARRANQUE;
                    end else begin
                        bus.trabajo_listo <= 1'b1;
                    end
                end
                ARRANQUE: begin
                    if (fin_arranque) begin
                        inicio <= 1'b0;
                        estado <= ESPERA;
                    end else begin
                        fase <= fase + FASE_W'(1);
                    end
                end
                ESPERA: begin
                    if (terminado) begin
                        bus.resultado_bounty <= bounty;
                        bus.resultado_estado <= EST_OK;
                        bus.resultado_valido <= 1'b1;
                        estado               <= ENTREGA;
                    end else if (expira) begin
                        bus.resultado_bounty <= '0;
                        bus.resultado_estado <= EST_TIMEOUT;
                        bus.resultado_valido <= 1'b1;
                        estado               <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (bus.resultado_listo) begin
                        bus.resultado_valido <= 1'b0;
                        bus.trabajo_listo    <= 1'b1;
                        ocupado              <= 1'b0;
                        estado               <= REPOSO;
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_despachador_hash.sv
// Self-checking bench for despachador_hash: directed table, reset corner cases,
// randomized jobs against a rule-based model, and timeout-counter saturation.
module tb_despachador_hash;
    import despachador_pkg::*;

    localparam int IC = 2;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    despachador_hash_if bus();

    logic [DATOS_W-1:0]    bloque_datos;
    logic [TARGET_W-1:0]   target;
    logic                  inicio;
    logic [BOUNTY_W-1:0]   bounty;
    logic                  terminado;
    logic [TIMEOUTS_W-1:0] contador_timeouts;
    logic                  ocupado;

    despachador_hash #(.INICIO_CICLOS(IC), .TIMEOUT_CICLOS(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .bloque_datos      (bloque_datos),
        .target            (target),
        .inicio            (inicio),
        .bounty            (bounty),
        .terminado         (terminado),
        .contador_timeouts (contador_timeouts),
        .ocupado           (ocupado)
    );

    typedef struct {
        logic [DATOS_W-1:0]  datos;
        logic [TARGET_W-1:0] tgt;
        int                  term;       // ESPERA cycle on which terminado is sampled; 0 = never
        logic [BOUNTY_W-1:0] bnty;
        int                  listo_wait; // cycles resultado_listo stays low
        estado_res_t         exp_est;
        logic [BOUNTY_W-1:0] exp_bnty;
        int                  exp_ciclos;
    } vec_t;

    int checks       = 0;
    int errors       = 0;
    int exp_timeouts = 0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BOUNTY_W-1:0] rand124();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[BOUNTY_W-1:0];
    endfunction

    function automatic logic [DATOS_W-1:0] rand96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Reference model: the outcome follows directly from when terminado arrives.
    function automatic vec_t modelo(input logic [DATOS_W-1:0] d, input logic [TARGET_W-1:0] t,
                                    input int term, input logic [BOUNTY_W-1:0] b, input int lw);
        vec_t v;
        bit ok;
        ok           = (term >= 1) && (term <= TO);
        v.datos      = d;
        v.tgt        = t;
        v.term       = term;
        v.bnty       = b;
        v.listo_wait = lw;
        v.exp_est    = ok ? EST_OK : EST_TIMEOUT;
        v.exp_bnty   = ok ? b : '0;
        v.exp_ciclos = ok ? term : TO;
        return v;
    endfunction

    task automatic ruido_core();
        terminado = 1'($urandom);
        bounty    = rand124();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trabajo_listo"}, 128'(bus.trabajo_listo), 128'(0));
        check({tag, "_res_valido"},    128'(bus.resultado_valido), 128'(0));
        check({tag, "_res_bounty"},    128'(bus.resultado_bounty), 128'(0));
        check({tag, "_res_estado"},    128'(bus.resultado_estado), 128'(0));
        check({tag, "_res_ciclos"},    128'(bus.resultado_ciclos), 128'(0));
        check({tag, "_bloque"},        128'(bloque_datos), 128'(0));
        check({tag, "_target"},        128'(target), 128'(0));
        check({tag, "_inicio"},        128'(inicio), 128'(0));
        check({tag, "_timeouts"},      128'(contador_timeouts), 128'(0));
        check({tag, "_ocupado"},       128'(ocupado), 128'(0));
    endtask

    // Offers a job and waits until the accepting edge has passed.
    task automatic aceptar(input logic [DATOS_W-1:0] d, input logic [TARGET_W-1:0] t, input bit ruido);
        int n;
        bus.trabajo_datos  = d;
        bus.trabajo_target = t;
        bus.trabajo_valido = 1'b1;
        n = 0;
        while (!bus.trabajo_listo && n < 40) begin
            if (ruido) ruido_core();
            step();
            n++;
        end
        check("listo_a_tiempo", 128'(n < 40), 128'(1));
        step();
        bus.trabajo_valido = 1'b0;
        bus.trabajo_datos  = rand96();
        bus.trabajo_target = 8'($urandom);
    endtask

    task automatic run_job(input vec_t v, input bit ruido);
        int c_end;
        aceptar(v.datos, v.tgt, ruido);
        check("acept_trabajo_listo", 128'(bus.trabajo_listo), 128'(0));
        check("acept_ocupado", 128'(ocupado), 128'(1));
        for (int i = 1; i <= IC; i++) begin
            if (ruido) ruido_core();
            check("inicio_alto", 128'(inicio), 128'(1));
            step();
        end
        check("inicio_bajo", 128'(inicio), 128'(0));

        c_end = 0;
        for (int c = 1; c <= TO + 4 && c_end == 0; c++) begin
            terminado = (c == v.term);
            bounty    = (c == v.term) ? v.bnty : rand124();
            check("espera_sin_result", 128'(bus.resultado_valido), 128'(0));
            step();
            if (bus.resultado_valido) c_end = c;
        end
        terminado = 1'b0;
        bounty    = rand124();
        check("fin_espera_ciclo", 128'(c_end), 128'(v.exp_ciclos));
        if (v.exp_est == EST_TIMEOUT && exp_timeouts < 255) exp_timeouts++;

        for (int w = 0; w <= v.listo_wait; w++) begin
            if (ruido) ruido_core();
            check("res_valido",    128'(bus.resultado_valido), 128'(1));
            check("res_estado",    128'(bus.resultado_estado), 128'(v.exp_est));
            check("res_bounty",    128'(bus.resultado_bounty), 128'(v.exp_bnty));
            check("res_ciclos",    128'(bus.resultado_ciclos), 128'(v.exp_ciclos));
            check("entrega_listo", 128'(bus.trabajo_listo), 128'(0));
            check("timeouts",      128'(contador_timeouts), 128'(exp_timeouts));
            check("bloque_estable", 128'(bloque_datos), 128'(v.datos));
            check("target_estable", 128'(target), 128'(v.tgt));
            if (w == v.listo_wait) bus.resultado_listo = 1'b1;
            step();
        end
        bus.resultado_listo = 1'b0;
        terminado = 1'b0;
        check("acept_res_valido", 128'(bus.resultado_valido), 128'(0));
        check("acept_res_listo",  128'(bus.trabajo_listo), 128'(1));
        check("acept_res_ocupado", 128'(ocupado), 128'(0));
    endtask

    // Reset asserted mid-cycle, some cycles after a job was accepted.
    task automatic reset_medio(input string tag, input int ciclos);
        aceptar(rand96(), 8'($urandom), 1'b0);
        repeat (ciclos) step();
        #2 reset = 1'b1;
        #1 check_all_zero(tag);
        step();
        reset = 1'b0;
        exp_timeouts = 0;
        check({tag, "_listo_tras_reset"}, 128'(bus.trabajo_listo), 128'(0));
        step();
        check({tag, "_listo_sube"}, 128'(bus.trabajo_listo), 128'(1));
    endtask

    initial begin
        bus.trabajo_valido  = 1'b0;
        bus.trabajo_datos   = '0;
        bus.trabajo_target  = '0;
        bus.resultado_listo = 1'b0;
        terminado           = 1'b0;
        bounty              = '0;

        vecs[0] = '{96'h0123456789ABCDEF01234567, 8'h10, 5, 124'hABC, 0, EST_OK, 124'hABC, 5};
        vecs[1] = '{96'hFEDCBA9876543210FEDCBA98, 8'h22, 0, 124'h555, 1, EST_TIMEOUT, 124'h0, 16};
        vecs[2] = '{96'h00000000000000000000000F, 8'h01, 16, 124'hDEADBEEF, 0, EST_OK, 124'hDEADBEEF, 16};
        vecs[3] = '{96'hAAAAAAAAAAAAAAAAAAAAAAAA, 8'hFF, 1, 124'h1, 10, EST_OK, 124'h1, 1};
        vecs[4] = '{96'h555555555555555555555555, 8'h80, 17, 124'h777, 2, EST_TIMEOUT, 124'h0, 16};
        vecs[5] = '{96'hFFFFFFFFFFFFFFFFFFFFFFFF, 8'h00, 15, {BOUNTY_W{1'b1}}, 0, EST_OK, {BOUNTY_W{1'b1}}, 15};

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        reset = 1'b0;
        check("listo_antes_flanco", 128'(bus.trabajo_listo), 128'(0));
        step();
        check("listo_tras_flanco", 128'(bus.trabajo_listo), 128'(1));

        for (int i = 0; i < 6; i++) run_job(vecs[i], 1'b0);

        reset_medio("rst_arranque", 0);
        reset_medio("rst_espera", IC + 3);
        run_job(modelo(96'h0BADC0FFEE0BADC0FFEE0123, 8'h42, 3, 124'h3A3, 0), 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_job(modelo(rand96(), 8'($urandom), $urandom_range(0, TO + 4),
                           rand124(), $urandom_range(0, 3)), 1'b1);
        end

        for (int i = 0; i < 256; i++) begin
            run_job(modelo(rand96(), 8'($urandom), 0, rand124(), 0), 1'b0);
        end
        check("timeouts_saturado", 128'(contador_timeouts), 128'(8'hFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/despachador_hash.md
# despachador_hash

Job dispatcher and result collector for the `micro_ucr_hash` mining core; it is the driving end of the core's `bloque_datos`/`inicio`/`target` → `bounty`/`terminado` interface. It accepts mining jobs from an upstream host over a valid/ready handshake and holds them stable on the core's inputs. It sequences `inicio` and watches `terminado` with a timeout guard. It returns each job's `bounty`, status and cycle count downstream over a second valid/ready handshake.

## Interface
- `INICIO_CICLOS`, 2: cycles `inicio` is held high per job; legal range ≥1.
- `TIMEOUT_CICLOS`, 1024: maximum `ESPERA` cycles before a job is aborted; legal range ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `trabajo_valido` in 1: upstream job present.
- `trabajo_listo` out 1: dispatcher can accept a job.
- `trabajo_datos` in 96: block data for the job.
- `trabajo_target` in 8: difficulty target for the job.
- `bloque_datos` out 96: to core, registered copy of the job data.
- `target` out 8: to core, registered copy of the job target.
- `inicio` out 1: to core, restart/start strobe.
- `bounty` in 124: from core.
- `terminado` in 1: from core, result found.
- `resultado_valido` out 1: result available.
- `resultado_listo` in 1: downstream accepts the result.
- `resultado_bounty` out 124: captured bounty; 0 on timeout.
- `resultado_estado` out 2: 00 = OK, 01 = TIMEOUT; 10 and 11 are reserved and never driven.
- `resultado_ciclos` out 16: `ESPERA` cycles used, saturating at 0xFFFF.
- `contador_timeouts` out 8: total timeouts since reset, saturating at 0xFF.
- `ocupado` out 1: high in every state except `REPOSO`.

## Operation
- FSM states: `REPOSO`, `ARRANQUE`, `ESPERA`, `ENTREGA`. Reset enters `REPOSO`.
- `REPOSO`:
  - `trabajo_listo`=1.
  - On `trabajo_valido & trabajo_listo` at an edge: capture data and target into `bloque_datos`/`target`, clear the phase counter, go to `ARRANQUE`.
- `ARRANQUE`:
  - `inicio`=1 for exactly `INICIO_CICLOS` cycles, then go to `ESPERA`.
  - `resultado_ciclos` counter cleared on entry to `ESPERA`.
- `ESPERA`:
  - `inicio`=0; the cycle counter increments every cycle.
  - `terminado` sampled high: capture `bounty`, estado=OK, go to `ENTREGA`.
  - Counter reaches `TIMEOUT_CICLOS` without `terminado`: bounty=0, estado=TIMEOUT, increment `contador_timeouts`, go to `ENTREGA`.
  - `terminado` and timeout in the same cycle: `terminado` wins, result is OK.
  - `terminado` is ignored outside `ESPERA`.
- `ENTREGA`:
  - `resultado_valido`=1 with all `resultado_*` held stable until `resultado_listo` is sampled high.
  - On acceptance: drop `resultado_valido`, return to `REPOSO`.
- `bloque_datos`/`target` stay stable from capture until the next job is accepted.
- `resultado_ciclos` counts `ESPERA` cycles including the sampling cycle.
- Reset mid-operation: immediate return to `REPOSO`; the in-flight job and any pending result are discarded; `inicio` drops asynchronously.

## Timing
- Reset values: every output 0, including `trabajo_listo`, `inicio` and `ocupado`.
- `trabajo_listo` rises at the first edge after `reset` deasserts.
- Job accepted at edge N:
  - `inicio` high in cycles N+1 … N+`INICIO_CICLOS`.
  - `ESPERA` begins at cycle N+`INICIO_CICLOS`+1.
- `terminado` sampled at edge M: `resultado_valido` high from cycle M+1.
- Result accepted at edge K: `trabajo_listo` high from cycle K+1.
- No job accepted in the same cycle a result is accepted; throughput is one job per round trip.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `despachador_pkg` holds:
  - FSM state encoding.
  - Status codes `EST_OK`=2'b00 and `EST_TIMEOUT`=2'b01.
  - Counter widths: 16 for `resultado_ciclos`, 8 for `contador_timeouts`.
- One sub-module, `contador_saturante` (parameterised width, clear, enable), used for both `resultado_ciclos` and `contador_timeouts`.
- Top level contains the FSM plus the data and result registers.

## Test plan
- Job 0x0123456789ABCDEF01234567 with target 0x10; `terminado` raised 5 cycles into `ESPERA` with bounty 0xABC → `inicio` high 2 cycles; result OK, bounty 0xABC, ciclos 5.
- `TIMEOUT_CICLOS`=16, `terminado` never asserted → result TIMEOUT, bounty 0, ciclos 16, `contador_timeouts`=1.
- `terminado` asserted exactly on the 16th `ESPERA` cycle → result OK, `contador_timeouts` unchanged.
- `resultado_listo` held low for 10 cycles → result fields stable and `trabajo_listo`=0 throughout; `trabajo_listo`=1 one cycle after acceptance.
- `reset` pulsed during `ESPERA` → all outputs 0 immediately; the next job runs normally with ciclos counted from 0.
- 256 forced timeouts → `contador_timeouts` saturates at 0xFF.
